// File: rtl/sum_accum_pkg.sv
// Shared state encoding and default widths for the sum_accum block.
package sum_accum_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefAccW  = 16;
  localparam int unsigned DefCntW  = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/acc_add.sv
// ACC_W-bit accumulator adder with carry flag.
// With SUM_ACCUM_SAT_EN defined the result clamps to all-ones on overflow.
module acc_add
  import sum_accum_pkg::*;
#(
  parameter int unsigned ACC_W = DefAccW
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [ACC_W-1:0] sample_i,
`ifdef SUM_ACCUM_SAT_EN
  input  logic             sat_i,
`endif
  output logic [ACC_W-1:0] sum_o,
  output logic             carry_o
);

  logic [ACC_W:0] raw;

  assign raw     = {1'b0, acc_i} + {1'b0, sample_i};
  assign carry_o = raw[ACC_W];

`ifdef SUM_ACCUM_SAT_EN
  // Once saturated, stay pinned at the maximum for the rest of the burst.
  assign sum_o = (sat_i || raw[ACC_W]) ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
  assign sum_o = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accum.sv
// Burst accumulator sitting downstream of an adder: sums len samples of {cout,sum}.
// Optional saturation on overflow when SUM_ACCUM_SAT_EN is defined.
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned ACC_W = DefAccW,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int unsigned PadW = ACC_W - WIDTH - 1;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ACC_W-1:0] sample;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;

  assign sample = {{PadW{1'b0}}, cout, sum};

  acc_add #(
    .ACC_W (ACC_W)
  ) u_acc_add (
    .acc_i    (acc_q),
    .sample_i (sample),
`ifdef SUM_ACCUM_SAT_EN
    .sat_i    (ovf_q),
`endif
    .sum_o    (add_sum),
    .carry_o  (add_carry)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;
    done_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = len;
          state_d = (len != '0) ? StAccum : StDone;
        end
      end
      StAccum: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_carry;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done_valid = 1'b1;
        // start is deliberately ignored here, even alongside done_ready.
        if (done_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc_out = acc_q;
  assign ovf     = ovf_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_sum_accum.sv
// Directed bench for sum_accum fed by a behavioural 8-bit adder with carry-in.
// Runs a 16-bit and a 10-bit accumulator side by side on the same stimulus.
module tb_sum_accum;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic       done_ready;
  logic [7:0] op_a, op_b;
  logic       op_ci;
  logic [7:0] sum;
  logic       cout;

  logic        in_ready, ovf, done_valid, busy;
  logic [15:0] acc_out;
  logic        in_ready10, ovf10, done_valid10, busy10;
  logic [9:0]  acc_out10;

  int tests_run;
  int tests_failed;

  assign {cout, sum} = {1'b0, op_a} + {1'b0, op_b} + {8'b0, op_ci};

  sum_accum u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum        (sum),
    .cout       (cout),
    .acc_out    (acc_out),
    .ovf        (ovf),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .busy       (busy)
  );

  sum_accum #(
    .WIDTH (8),
    .ACC_W (10),
    .CNT_W (4)
  ) u_dut10 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready10),
    .sum        (sum),
    .cout       (cout),
    .acc_out    (acc_out10),
    .ovf        (ovf10),
    .done_valid (done_valid10),
    .done_ready (done_ready),
    .busy       (busy10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input logic [7:0] a, input logic [7:0] b, input logic ci);
    op_a  = a;
    op_b  = b;
    op_ci = ci;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    tests_run++;
    if ({busy, in_ready, done_valid, ovf} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b, expected 0000", {busy, in_ready, done_valid, ovf});
    end
    tests_run++;
    if (acc_out !== 16'h0000 || u_dut.cnt_q !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_acc_cnt: got acc %h cnt %h, expected 0000 0", acc_out, u_dut.cnt_q);
    end
    tests_run++;
    if ({busy10, in_ready10, done_valid10, ovf10} !== 4'b0000 || acc_out10 !== 10'h000) begin
      tests_failed++;
      $display("FAIL reset_dut10: got flags %b acc %h, expected 0000 000",
               {busy10, in_ready10, done_valid10, ovf10}, acc_out10);
    end
    repeat (2) tick;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    start = 1'b1;
    len   = 4'd3;
    tick;
    start = 1'b0;
    tests_run++;
    if ({busy, in_ready, done_valid} !== 3'b110 || acc_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL basic_enter_accum: got flags %b acc %h, expected 110 0000",
               {busy, in_ready, done_valid}, acc_out);
    end
    in_valid = 1'b1;
    set_sample(8'h10, 8'h00, 1'b0);
    tick;
    tests_run++;
    if (acc_out !== 16'h0010 || done_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_first_accept: got acc %h dv %b, expected 0010 0", acc_out, done_valid);
    end
    set_sample(8'h20, 8'h00, 1'b0);
    tick;
    set_sample(8'h80, 8'h85, 1'b0);
    tick;
    in_valid = 1'b0;
    tests_run++;
    if ({done_valid, in_ready, ovf} !== 3'b100 || acc_out !== 16'h0135) begin
      tests_failed++;
      $display("FAIL basic_done: got flags %b acc %h, expected 100 0135",
               {done_valid, in_ready, ovf}, acc_out);
    end
    tests_run++;
    if (acc_out10 !== 10'h135 || ovf10 !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done10: got acc %h ovf %b, expected 135 0", acc_out10, ovf10);
    end
    done_ready = 1'b1;
    tick;
    done_ready = 1'b0;
    tests_run++;
    if ({busy, done_valid} !== 2'b00 || acc_out !== 16'h0135) begin
      tests_failed++;
      $display("FAIL basic_idle: got flags %b acc %h, expected 00 0135", {busy, done_valid}, acc_out);
    end
  endtask

  task automatic test_len0;
    start = 1'b1;
    len   = 4'd0;
    tick;
    start = 1'b0;
    tests_run++;
    if ({done_valid, in_ready, busy, ovf} !== 4'b1010 || acc_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL len0_done: got flags %b acc %h, expected 1010 0000",
               {done_valid, in_ready, busy, ovf}, acc_out);
    end
    done_ready = 1'b1;
    tick;
    done_ready = 1'b0;
    tests_run++;
    if ({busy, in_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL len0_idle: got %b, expected 00", {busy, in_ready});
    end
  endtask

  task automatic test_wrap;
    logic [9:0] exp_acc10;
`ifdef SUM_ACCUM_SAT_EN
    exp_acc10 = 10'h3FF;
`else
    exp_acc10 = 10'h1FB;
`endif
    start = 1'b1;
    len   = 4'd5;
    tick;
    start    = 1'b0;
    in_valid = 1'b1;
    set_sample(8'hFF, 8'hFF, 1'b1);
    repeat (5) tick;
    in_valid = 1'b0;
    tests_run++;
    if (acc_out10 !== exp_acc10 || ovf10 !== 1'b1 || done_valid10 !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_acc10: got acc %h ovf %b dv %b, expected %h 1 1",
               acc_out10, ovf10, done_valid10, exp_acc10);
    end
    tests_run++;
    if (acc_out !== 16'h09FB || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_acc16: got acc %h ovf %b, expected 09fb 0", acc_out, ovf);
    end
    done_ready = 1'b1;
    tick;
    done_ready = 1'b0;
  endtask

  task automatic test_gaps;
    logic [15:0] exp_acc;
    exp_acc = 16'h0000;
    start   = 1'b1;
    len     = 4'd4;
    tick;
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_sample(8'(i), 8'h00, 1'b0);
      in_valid = 1'b1;
      tick;
      exp_acc  = exp_acc + 16'(i);
      in_valid = 1'b0;
      set_sample(8'h55, 8'h55, 1'b0);
      if (i < 4) begin
        for (int g = 0; g < 2; g++) begin
          tick;
          tests_run++;
          if (acc_out !== exp_acc || {in_ready, done_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL gap_hold: got acc %h flags %b, expected %h 10",
                     acc_out, {in_ready, done_valid}, exp_acc);
          end
        end
      end
    end
    tests_run++;
    if (done_valid !== 1'b1 || acc_out !== 16'h000A || ovf !== 1'b0 || ovf10 !== 1'b0) begin
      tests_failed++;
      $display("FAIL gap_done: got dv %b acc %h ovf %b ovf10 %b, expected 1 000a 0 0",
               done_valid, acc_out, ovf, ovf10);
    end
    for (int w = 0; w < 5; w++) begin
      tick;
      tests_run++;
      if ({done_valid, busy, in_ready} !== 3'b110 || acc_out !== 16'h000A) begin
        tests_failed++;
        $display("FAIL gap_stall: got flags %b acc %h, expected 110 000a",
                 {done_valid, busy, in_ready}, acc_out);
      end
    end
    done_ready = 1'b1;
    tick;
    done_ready = 1'b0;
    tests_run++;
    if ({busy, done_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL gap_release: got %b, expected 00", {busy, done_valid});
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1;
    len   = 4'd4;
    tick;
    start    = 1'b0;
    in_valid = 1'b1;
    set_sample(8'h20, 8'h00, 1'b0);
    repeat (2) tick;
    in_valid = 1'b0;
    tests_run++;
    if (acc_out !== 16'h0040 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_partial: got acc %h busy %b, expected 0040 1", acc_out, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, in_ready, done_valid, ovf} !== 4'b0000 || acc_out !== 16'h0000
        || u_dut.cnt_q !== 4'h0) begin
      tests_failed++;
      $display("FAIL mid_async_reset: got flags %b acc %h cnt %h, expected 0000 0000 0",
               {busy, in_ready, done_valid, ovf}, acc_out, u_dut.cnt_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    len   = 4'd1;
    tick;
    start = 1'b0;
    tests_run++;
    if ({busy, in_ready} !== 2'b11 || acc_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL mid_first_start: got flags %b acc %h, expected 11 0000",
               {busy, in_ready}, acc_out);
    end
    set_sample(8'h03, 8'h04, 1'b0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tests_run++;
    if (done_valid !== 1'b1 || acc_out !== 16'h0007) begin
      tests_failed++;
      $display("FAIL mid_restart: got dv %b acc %h, expected 1 0007", done_valid, acc_out);
    end
    done_ready = 1'b1;
    tick;
    done_ready = 1'b0;
  endtask

  task automatic test_start_ignored;
    start = 1'b1;
    len   = 4'd2;
    tick;
    start = 1'b0;
    set_sample(8'h11, 8'h00, 1'b0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    start    = 1'b1;
    len      = 4'd5;
    tick;
    start = 1'b0;
    tests_run++;
    if (acc_out !== 16'h0011 || {in_ready, done_valid} !== 2'b10 || u_dut.cnt_q !== 4'h1) begin
      tests_failed++;
      $display("FAIL start_in_accum: got acc %h flags %b cnt %h, expected 0011 10 1",
               acc_out, {in_ready, done_valid}, u_dut.cnt_q);
    end
    set_sample(8'h22, 8'h00, 1'b0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tests_run++;
    if (done_valid !== 1'b1 || acc_out !== 16'h0033) begin
      tests_failed++;
      $display("FAIL start_done_entry: got dv %b acc %h, expected 1 0033", done_valid, acc_out);
    end
    start = 1'b1;
    tick;
    tests_run++;
    if (done_valid !== 1'b1 || acc_out !== 16'h0033) begin
      tests_failed++;
      $display("FAIL start_in_done: got dv %b acc %h, expected 1 0033", done_valid, acc_out);
    end
    done_ready = 1'b1;
    tick;
    start      = 1'b0;
    done_ready = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_with_release: got busy %b, expected 0", busy);
    end
    tick;
    tests_run++;
    if (busy !== 1'b0 || acc_out !== 16'h0033) begin
      tests_failed++;
      $display("FAIL start_not_captured: got busy %b acc %h, expected 0 0033", busy, acc_out);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    len          = 4'd0;
    in_valid     = 1'b0;
    done_ready   = 1'b0;
    op_a         = 8'h00;
    op_b         = 8'h00;
    op_ci        = 1'b0;

    test_reset;
    test_basic;
    test_len0;
    test_wrap;
    test_gaps;
    test_reset_mid;
    test_start_ignored;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
